// File: rtl/dsa_simd_write_packer_if.sv
// -----------------------------------------------------------------------------
// dsa_simd_write_packer_if
//   Pixel stream from the bilinear datapath into the write packer.
//   in_valid  : upstream pixel valid
//   in_ready  : packer accepts the pixel this cycle (driven by the packer)
//   in_addr   : byte address of the pixel
//   in_data   : pixel value
//   in_last   : final pixel of the frame, qualified by accept
//   Modports: master = upstream producer, slave = packer.
// -----------------------------------------------------------------------------
interface dsa_simd_write_packer_if #(
  parameter int ADDR_WIDTH = 18
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [7:0]            in_data;
  logic                  in_last;

  modport master (
    output in_valid,
    output in_addr,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_addr,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/dsa_simd_write_packer.sv
// -----------------------------------------------------------------------------
// dsa_simd_write_packer
//   Collects byte pixels that fall into the same 4-byte-aligned group and
//   issues one SIMD write when all four lanes are present. Incomplete groups
//   (edges, non-contiguous addresses, end of frame) are drained as ascending
//   single-byte writes so the memory never sees an unaligned SIMD write.
//
//   Ports:
//     clk, rst_n          : clock (rising edge), asynchronous active-low reset
//     pix (slave)         : pixel stream in_valid/in_ready/in_addr/in_data/in_last
//     simd_write_en       : one-cycle SIMD write strobe
//     simd_base_addr      : aligned SIMD address ([1:0] = 0)
//     simd_data_0..3      : lane 0..3 bytes
//     write_en            : one-cycle single-byte write strobe
//     write_addr/data     : single write address / byte
//     done                : one-cycle pulse with the final write of a frame
//     stat_simd_cnt       : SIMD writes issued (statistics build only)
//     stat_single_cnt     : single writes issued (statistics build only)
//
//   Build option: define DSA_PACKER_STATS_EN to build the saturating write
//   counters; otherwise both stat ports are tied to 0.
//   All outputs are registered except in_ready (combinational from in_addr).
// -----------------------------------------------------------------------------
module dsa_simd_write_packer #(
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dsa_simd_write_packer_if.slave pix,
  output logic                  simd_write_en,
  output logic [ADDR_WIDTH-1:0] simd_base_addr,
  output logic [7:0]            simd_data_0,
  output logic [7:0]            simd_data_1,
  output logic [7:0]            simd_data_2,
  output logic [7:0]            simd_data_3,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [7:0]            write_data,
  output logic                  done,
  output logic [31:0]           stat_simd_cnt,
  output logic [31:0]           stat_single_cnt
);

  localparam int GW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                r_state, w_state_nx;
  logic [7:0]            r_buf [4];
  logic [7:0]            w_buf_nx [4];
  logic [3:0]            r_mask, w_mask_nx;
  logic [GW-1:0]         r_base, w_base_nx;
  logic                  r_pend_last, w_pend_last_nx;

  logic                  r_simd_en, w_simd_en_nx;
  logic [ADDR_WIDTH-1:0] r_simd_addr, w_simd_addr_nx;
  logic [31:0]           r_simd_data, w_simd_data_nx;
  logic                  r_wr_en, w_wr_en_nx;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nx;
  logic [7:0]            r_wr_data, w_wr_data_nx;
  logic                  r_done, w_done_nx;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic [GW-1:0] w_group;
  logic [1:0]    w_lane;
  logic          w_conflict;
  logic          w_ready;
  logic          w_accept;

  assign w_group    = pix.in_addr[ADDR_WIDTH-1:2];
  assign w_lane     = pix.in_addr[1:0];
  assign w_conflict = (r_state == FILL) && pix.in_valid &&
                      ((w_group != r_base) || r_mask[w_lane]);
  assign w_ready    = (r_state != DRAIN) && !w_conflict;
  assign w_accept   = pix.in_valid && w_ready;
  assign pix.in_ready = w_ready;

  // ---------------------------------------------------------------------------
  // Buffer contents including this cycle's accepted pixel. The first drain
  // write is issued from this merged view so that the write strobes fill the
  // k cycles directly after the conflict/last cycle.
  // ---------------------------------------------------------------------------
  logic [3:0]    w_mmask;
  logic [7:0]    w_mbuf [4];
  logic [GW-1:0] w_mbase;
  logic [1:0]    w_dlane;
  logic [3:0]    w_drest;

  always_comb begin
    w_mmask = r_mask;
    for (int unsigned i = 0; i < 4; i++) begin
      w_mbuf[i] = r_buf[i];
    end
    w_mbase = (r_state == EMPTY) ? w_group : r_base;
    if (w_accept) begin
      w_mmask[w_lane] = 1'b1;
      w_mbuf[w_lane]  = pix.in_data;
    end
  end

  always_comb begin
    w_dlane = 2'd3;
    if (w_mmask[0])      w_dlane = 2'd0;
    else if (w_mmask[1]) w_dlane = 2'd1;
    else if (w_mmask[2]) w_dlane = 2'd2;
    w_drest = w_mmask & ~(4'b0001 << w_dlane);
  end

  // ---------------------------------------------------------------------------
  // Next state / outputs
  // ---------------------------------------------------------------------------
  logic w_drain_step;
  logic w_last_now;

  assign w_last_now = w_accept && pix.in_last;

  always_comb begin
    w_state_nx     = r_state;
    w_mask_nx      = r_mask;
    for (int unsigned i = 0; i < 4; i++) begin
      w_buf_nx[i] = r_buf[i];
    end
    w_base_nx      = r_base;
    w_pend_last_nx = r_pend_last;
    w_simd_en_nx   = 1'b0;
    w_simd_addr_nx = r_simd_addr;
    w_simd_data_nx = r_simd_data;
    w_wr_en_nx     = 1'b0;
    w_wr_addr_nx   = r_wr_addr;
    w_wr_data_nx   = r_wr_data;
    w_done_nx      = 1'b0;
    w_drain_step   = 1'b0;

    unique case (r_state)
      EMPTY, FILL: begin
        if (w_accept) begin
          w_base_nx = w_mbase;
          if (w_mmask == 4'hF) begin
            // Group complete: SIMD write, buffer cleared so a new group can
            // open next cycle without a bubble.
            w_simd_en_nx   = 1'b1;
            w_simd_addr_nx = {w_mbase, 2'b00};
            w_simd_data_nx = {w_mbuf[3], w_mbuf[2], w_mbuf[1], w_mbuf[0]};
            w_mask_nx      = '0;
            for (int unsigned i = 0; i < 4; i++) begin
              w_buf_nx[i] = '0;
            end
            w_state_nx     = EMPTY;
            if (pix.in_last || r_pend_last) begin
              w_done_nx      = 1'b1;
              w_pend_last_nx = 1'b0;
            end
          end else if (pix.in_last) begin
            w_drain_step = 1'b1;
          end else begin
            w_mask_nx = w_mmask;
            for (int unsigned i = 0; i < 4; i++) begin
              w_buf_nx[i] = w_mbuf[i];
            end
            w_state_nx = FILL;
          end
        end else if (w_conflict) begin
          w_drain_step = 1'b1;
        end
      end
      DRAIN: begin
        if (r_mask != 4'b0000) w_drain_step = 1'b1;
        else                   w_state_nx   = EMPTY;
      end
      default: w_state_nx = EMPTY;
    endcase

    if (w_drain_step) begin
      w_wr_en_nx   = 1'b1;
      w_wr_addr_nx = {w_mbase, w_dlane};
      w_wr_data_nx = w_mbuf[w_dlane];
      w_mask_nx    = w_drest;
      for (int unsigned i = 0; i < 4; i++) begin
        w_buf_nx[i] = w_mbuf[i];
      end
      w_base_nx    = w_mbase;
      w_state_nx   = DRAIN;
      if ((w_drest == 4'b0000) && (r_pend_last || w_last_now)) begin
        w_done_nx      = 1'b1;
        w_pend_last_nx = 1'b0;
      end else if (w_last_now) begin
        w_pend_last_nx = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      for (int unsigned i = 0; i < 4; i++) begin
        r_buf[i] <= '0;
      end
      r_mask      <= '0;
      r_base      <= '0;
      r_pend_last <= 1'b0;
      r_simd_en   <= 1'b0;
      r_simd_addr <= '0;
      r_simd_data <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      for (int unsigned i = 0; i < 4; i++) begin
        r_buf[i] <= w_buf_nx[i];
      end
      r_mask      <= w_mask_nx;
      r_base      <= w_base_nx;
      r_pend_last <= w_pend_last_nx;
      r_simd_en   <= w_simd_en_nx;
      r_simd_addr <= w_simd_addr_nx;
      r_simd_data <= w_simd_data_nx;
      r_wr_en     <= w_wr_en_nx;
      r_wr_addr   <= w_wr_addr_nx;
      r_wr_data   <= w_wr_data_nx;
      r_done      <= w_done_nx;
    end
  end

  assign simd_write_en  = r_simd_en;
  assign simd_base_addr = r_simd_addr;
  assign simd_data_0    = r_simd_data[7:0];
  assign simd_data_1    = r_simd_data[15:8];
  assign simd_data_2    = r_simd_data[23:16];
  assign simd_data_3    = r_simd_data[31:24];
  assign write_en       = r_wr_en;
  assign write_addr     = r_wr_addr;
  assign write_data     = r_wr_data;
  assign done           = r_done;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef DSA_PACKER_STATS_EN
  logic [31:0] r_simd_cnt;
  logic [31:0] r_single_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_simd_cnt   <= '0;
      r_single_cnt <= '0;
    end else begin
      if (r_simd_en && (r_simd_cnt != '1))
        r_simd_cnt <= r_simd_cnt + 32'd1;
      if (r_wr_en && (r_single_cnt != '1))
        r_single_cnt <= r_single_cnt + 32'd1;
    end
  end

  assign stat_simd_cnt   = r_simd_cnt;
  assign stat_single_cnt = r_single_cnt;
`else
  assign stat_simd_cnt   = '0;
  assign stat_single_cnt = '0;
`endif

endmodule
